// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction/data requesters,
// with lock-driven bursts bounded by BURST_MAX. Optional ARB_DATA_PRIORITY_EN.
module ram_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        wen,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*ADDR_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rwait,
  output logic [ADDR_W-1:0]      rdata,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [ADDR_W-1:0]      ramstore,
  input  logic [ADDR_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [NREQ-1:0]    gnt_reg, gnt_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   wcount_reg, wcount_next;

  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [ADDR_W-1:0]  wdata_arr [NREQ];
  logic [NREQ-1:0]    cand;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = wdata[gi*ADDR_W +: ADDR_W];
  end

`ifdef ARB_DATA_PRIORITY_EN
  logic [NREQ-1:0] data_mask;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign data_mask[gi] = (gi >= NREQ/2);
  end
  // Data requesters shadow instruction requesters; round-robin inside the class.
  assign cand = (|(req & data_mask)) ? (req & data_mask) : req;
`else
  assign cand = req;
`endif

  // Scan from the farthest offset down so the nearest candidate at/after ptr wins.
  always_comb begin
    int s;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(ptr_reg) + k;
      if (s >= NREQ) s = s - NREQ;
      if (cand[s]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(s);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      wcount_reg <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      wcount_reg <= wcount_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    owner_next  = owner_reg;
    ptr_next    = ptr_reg;
    wcount_next = wcount_reg;
    rwait       = '1;
    rdata       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next  = BUSY;
          gnt_next    = NREQ'(1) << pick_idx;
          owner_next  = pick_idx;
          wcount_next = '0;
        end
      end
      BUSY: begin
        ramaddr = addr_arr[owner_reg];
        if (wen[owner_reg]) begin
          ramWEN   = 1'b1;
          ramstore = wdata_arr[owner_reg];
        end else begin
          ramREN = 1'b1;
          rdata  = ramload;
        end
        if (!req[owner_reg]) begin
          // Abort: release without a completion pulse, pointer untouched.
          state_next = IDLE;
          gnt_next   = '0;
        end else if (ramstate == RAM_ACCESS) begin
          rwait[owner_reg] = 1'b0;
          wcount_next      = wcount_reg + CNT_W'(1);
          if (!(lock[owner_reg] && (int'(wcount_reg) + 1 < BURST_MAX))) begin
            state_next = IDLE;
            gnt_next   = '0;
            ptr_next   = (int'(owner_reg) == NREQ - 1) ? '0 : owner_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt = gnt_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expected words,
// a negedge monitor pops and compares each completion.
module tb_ram_port_arbiter;

  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0, wen = '0, lock = '0;
  logic [31:0] addr_a  [4];
  logic [31:0] wdata_a [4];
  logic [127:0] addr, wdata;
  logic [3:0]  gnt, rwait;
  logic [31:0] rdata, ramaddr, ramstore, ramload;
  logic        ramREN, ramWEN;
  logic [1:0]  ramstate;
  logic [1:0]  ram_mode = RS_ACCESS;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic        wr;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  assign addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};
  // RAM model: answers with ram_mode whenever enabled
  assign ramstate = (ramREN | ramWEN) ? ram_mode : RS_FREE;
  assign ramload  = (ramaddr == 32'h100) ? 32'hDEADBEEF : {16'hCAFE, ramaddr[15:0]};

  ram_port_arbiter #(.NREQ(4), .BURST_MAX(2), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wen(wen), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rwait(rwait), .rdata(rdata),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] a, input logic wr, input logic [31:0] d);
    exp_t e;
    e.idx = idx; e.a = a; e.wr = wr; e.d = d;
    q.push_back(e);
  endtask

  // Returns the index of the next completing requester, or -1 on timeout.
  task automatic wait_done(output int idx);
    idx = -1;
    for (int n = 0; n < 30 && idx < 0; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) if (!rwait[i]) idx = i;
    end
    if (idx < 0) check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_gnt(input logic [3:0] g);
    bit seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge CLK);
      if (gnt == g) seen = 1;
    end
    check("wait_gnt", 32'(gnt), 32'(g));
  endtask

  // Monitor: every completion must match the head of the scoreboard
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge CLK);
      if (!RST && rwait != 4'hF) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!rwait[i]) idx = i;
        check("mon_onehot_rwait", 32'($countones(~rwait)), 32'd1);
        if (q.size() == 0) begin
          check("mon_unexpected_word", 32'(idx), 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          check("mon_owner", 32'(idx), 32'(e.idx));
          check("mon_gnt", 32'(gnt), 32'(4'b1 << e.idx));
          check("mon_addr", ramaddr, e.a);
          check("mon_wen", {30'd0, ramWEN, ramREN}, e.wr ? 32'd2 : 32'd1);
          check("mon_data", e.wr ? ramstore : rdata, e.d);
        end
      end
    end
  end

  initial begin
    int idx;
    int order[4];
    for (int i = 0; i < 4; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end

    // Reset and idle
    @(negedge CLK);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rwait", 32'(rwait), 32'hF);
    check("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    tick(); RST = 1'b0;
    tick(); tick();
    @(negedge CLK);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_rwait", 32'(rwait), 32'hF);

    // Single read with 1-cycle RAM
    tick();
    req = 4'b0001; wen = 4'b0000; addr_a[0] = 32'h100;
    push(0, 32'h100, 1'b0, 32'hDEADBEEF);
    @(negedge CLK);
    check("rd_gnt_t", 32'(gnt), 32'h0);
    @(negedge CLK);
    check("rd_gnt_t1", 32'(gnt), 32'h1);
    check("rd_rwait_t1", 32'(rwait), 32'hE);
    check("rd_rdata_t1", rdata, 32'hDEADBEEF);
    tick(); req = 4'b0000;
    @(negedge CLK);
    check("rd_idle_t2", 32'(gnt), 32'h0);

    // Abort while RAM is busy: no pulse, pointer stays at 1
    ram_mode = RS_BUSY;
    tick();
    req = 4'b0100; addr_a[2] = 32'h400;
    @(negedge CLK);
    @(negedge CLK);
    check("ab_gnt", 32'(gnt), 32'h4);
    check("ab_rwait_busy", 32'(rwait), 32'hF);
    tick(); req = 4'b0000;
    @(negedge CLK);
    check("ab_rwait_drop", 32'(rwait), 32'hF);
    tick();
    @(negedge CLK);
    check("ab_idle", 32'(gnt), 32'h0);
    ram_mode = RS_ACCESS;
    tick();
    for (int i = 0; i < 4; i++) addr_a[i] = 32'h10 + 32'(i);
    req = 4'b1111;
`ifdef ARB_DATA_PRIORITY_EN
    push(2, 32'h12, 1'b0, 32'hCAFE0012);
`else
    push(1, 32'h11, 1'b0, 32'hCAFE0011);
`endif
    wait_done(idx);
    tick(); req = 4'b0000;

    // ERROR for three cycles keeps the request driven
    ram_mode = RS_ERROR;
    tick();
    req = 4'b0001; addr_a[0] = 32'h300;
    @(negedge CLK);
    @(negedge CLK);
    check("err_gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 3; k++) begin
      check("err_rwait", 32'(rwait), 32'hF);
      check("err_ren", {31'd0, ramREN}, 32'd1);
      check("err_addr", ramaddr, 32'h300);
      if (k < 2) @(negedge CLK);
    end
    tick();
    ram_mode = RS_ACCESS;
    push(0, 32'h300, 1'b0, 32'hCAFE0300);
    wait_done(idx);
    tick(); req = 4'b0000;

    // Async reset during a locked write burst
    ram_mode = RS_BUSY;
    tick();
    req = 4'b1000; wen = 4'b1000; lock = 4'b1000; addr_a[3] = 32'h500; wdata_a[3] = 32'h55;
    wait_gnt(4'b1000);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt), 32'h0);
    check("ar_wen", {31'd0, ramWEN}, 32'd0);
    check("ar_rwait", 32'(rwait), 32'hF);
    req = '0; wen = '0; lock = '0;
    tick(); RST = 1'b0;
    ram_mode = RS_ACCESS;
    tick();

    // Contention: each requester drops after its word; pointer restarted at 0
`ifdef ARB_DATA_PRIORITY_EN
    order = '{2, 3, 0, 1};
`else
    order = '{0, 1, 2, 3};
`endif
    for (int i = 0; i < 4; i++) addr_a[i] = 32'h600 + 32'(4*i);
    for (int i = 0; i < 4; i++) push(order[i], 32'h600 + 32'(4*order[i]), 1'b0, 32'hCAFE0600 + 32'(4*order[i]));
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_done(idx);
      tick();
      if (idx >= 0) req[idx] = 1'b0;
    end
    req = '0;
    tick();

    // Locked writeback: two words back-to-back, third needs a new grant
    req = 4'b1000; wen = 4'b1000; lock = 4'b1000;
    addr_a[3] = 32'h200; wdata_a[3] = 32'h11111111;
    push(3, 32'h200, 1'b1, 32'h11111111);
    push(3, 32'h204, 1'b1, 32'h22222222);
    @(negedge CLK);
    @(negedge CLK);
    check("lk_gnt_w1", 32'(gnt), 32'h8);
    check("lk_rwait_w1", 32'(rwait), 32'h7);
    tick();
    addr_a[3] = 32'h204; wdata_a[3] = 32'h22222222;
    @(negedge CLK);
    check("lk_gnt_w2", 32'(gnt), 32'h8);
    check("lk_rwait_w2", 32'(rwait), 32'h7);
    tick();
    addr_a[3] = 32'h208; wdata_a[3] = 32'h33333333;
    push(3, 32'h208, 1'b1, 32'h33333333);
    @(negedge CLK);
    check("lk_release", 32'(gnt), 32'h0);
    @(negedge CLK);
    check("lk_gnt_w3", 32'(gnt), 32'h8);
    check("lk_rwait_w3", 32'(rwait), 32'h7);
    tick();
    req = '0; wen = '0; lock = '0;
    tick(); tick();
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
